// File: rtl/dpscram.sv
// DisplayPort main-link scrambler: scrambles data symbols of a 4-symbol word with
// the G(X)=X^16+X^5+X^4+X^3+1 LFSR, replaces every 512th BS with SR, one-cycle latency.
module dpscram (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] indata,
    input  logic [3:0]  inisk,
    output logic [31:0] outdata,
    output logic [3:0]  outisk
);

    localparam logic [7:0] SYM_BS = 8'hBC;
    localparam logic [7:0] SYM_SR = 8'h1C;

    logic [15:0] lfsr;
    logic [8:0]  bscnt;

    logic [15:0] lfsr_nxt;
    logic [8:0]  bscnt_nxt;
    logic [31:0] data_nxt;
    logic [31:0] din;
    logic [3:0]  kin;
    logic [7:0]  byt;
    logic [7:0]  ks;
    logic        k;
    logic        o;

    // Byte slots are chained: each one consumes the LFSR/BS-count state left by the
    // previous slot. Input bytes are shifted out LSB-first, results shifted in MSB-first.
    always_comb begin
        lfsr_nxt  = lfsr;
        bscnt_nxt = bscnt;
        data_nxt  = '0;
        din       = indata;
        kin       = inisk;
        byt       = '0;
        ks        = '0;
        k         = 1'b0;
        o         = 1'b0;
        for (int unsigned b = 0; b < 4; b++) begin
            byt = din[7:0];
            k   = kin[0];
            din = {8'h00, din[31:8]};
            kin = {1'b0, kin[3:1]};
            if (k && byt == SYM_BS) begin
                if (bscnt_nxt == '0)
                    byt = SYM_SR;
                bscnt_nxt = bscnt_nxt + 9'd1;
            end
            if (k && byt == SYM_SR) begin
                lfsr_nxt = '1;
            end else begin
                ks = '0;
                for (int unsigned i = 0; i < 8; i++) begin
                    o        = lfsr_nxt[15];
                    ks       = {o, ks[7:1]};
                    lfsr_nxt = {lfsr_nxt[14:0], o} ^ {10'b0, o, o, o, 3'b000};
                end
                if (!k)
                    byt = byt ^ ks;
            end
            data_nxt = {byt, data_nxt[31:8]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outdata <= '0;
            outisk  <= '0;
            lfsr    <= '1;
            bscnt   <= '0;
        end else if (en) begin
            outdata <= data_nxt;
            outisk  <= inisk;
            lfsr    <= lfsr_nxt;
            bscnt   <= bscnt_nxt;
        end else begin
            outdata <= indata;
            outisk  <= inisk;
            lfsr    <= '1;
            bscnt   <= '0;
        end
    end

endmodule

// File: tb/tb_dpscram.sv
// Self-checking bench for dpscram: keystream-position reference model checked every
// cycle, plus directed literal expectations from hand-derived scrambler output.
module tb_dpscram;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b1;
    logic [31:0] indata = '0;
    logic [3:0]  inisk = '0;
    logic [31:0] outdata;
    logic [3:0]  outisk;

    int checks = 0;
    int errors = 0;

    dpscram dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .indata (indata),
        .inisk  (inisk),
        .outdata(outdata),
        .outisk (outisk)
    );

    always #5 clk = ~clk;

    // Reference: the scrambler keystream is one fixed PRBS starting from all-ones.
    // The model only tracks the bit position into it and how many BS have been seen.
    localparam int PERIOD = 65535;
    bit          kbit [PERIOD];
    int          pos = 0;
    int          nbs = 0;
    logic [31:0] exp_d;
    logic [3:0]  exp_k;
    bit          valid = 0;

    function automatic logic [7:0] ksbyte(int p);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = kbit[(p + i) % PERIOD];
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        logic [15:0] l;
        logic        ob;
        l = 16'hFFFF;
        for (int n = 0; n < PERIOD; n++) begin
            ob = l[15];
            kbit[n] = ob;
            l = ({l[14:0], 1'b0} ^ (ob ? 16'h0038 : 16'h0000)) | {15'b0, ob};
        end
    end

    always @(posedge clk) begin
        logic [7:0] by;
        if (reset) begin
            exp_d = '0; exp_k = '0; pos = 0; nbs = 0;
        end else if (!en) begin
            exp_d = indata; exp_k = inisk; pos = 0; nbs = 0;
        end else begin
            exp_k = inisk;
            for (int b = 0; b < 4; b++) begin
                by = indata[8*b +: 8];
                if (inisk[b] && by == 8'hBC) begin
                    if (nbs % 512 == 0) by = 8'h1C;
                    nbs++;
                end
                if (inisk[b] && by == 8'h1C) begin
                    pos = 0;
                end else begin
                    if (!inisk[b]) by = by ^ ksbyte(pos);
                    pos = (pos + 8) % PERIOD;
                end
                exp_d[8*b +: 8] = by;
            end
        end
        valid = 1;
    end

    always @(negedge clk) begin
        if (valid) begin
            check("model_data", outdata, exp_d);
            check("model_isk", {28'h0, outisk}, {28'h0, exp_k});
        end
    end

    task automatic drive(logic r, logic e, logic [31:0] d, logic [3:0] k);
        @(negedge clk);
        reset = r; en = e; indata = d; inisk = k;
    endtask

    task automatic lit(string name, logic [31:0] d, logic [3:0] k);
        @(posedge clk);
        #1;
        check({name, "_data"}, outdata, d);
        check({name, "_isk"}, {28'h0, outisk}, {28'h0, k});
    endtask

    initial begin
        logic [31:0] rd;
        logic [3:0]  rk;
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic [3:0]  rk;
        logic [7:0]  by;
        #1;
        check("ks0", {24'h0, ksbyte(0)},  32'hFF);
        check("ks1", {24'h0, ksbyte(8)},  32'h17);
        check("ks2", {24'h0, ksbyte(16)}, 32'hC0);
        check("ks3", {24'h0, ksbyte(24)}, 32'h14);
        check("ks4", {24'h0, ksbyte(32)}, 32'hB2);

        drive(1, 1, 32'hDEADBEEF, 4'hF); lit("reset", 32'h0, 4'h0);
        drive(0, 1, 32'h0, 4'h0);        lit("zero", 32'h14C017FF, 4'h0);
        drive(0, 1, 32'h0, 4'h0);        @(posedge clk); #1;
        check("cont_b2", {24'h0, outdata[7:0]}, 32'hB2);

        drive(1, 1, 32'h0, 4'h0);
        drive(0, 1, 32'h00BC0000, 4'b0100); lit("bs_byte2", 32'hFF1C17FF, 4'b0100);

        drive(1, 1, 32'h0, 4'h0);
        drive(0, 1, 32'h000000FB, 4'b0001); lit("be_k", 32'h14C017FB, 4'b0001);

        drive(0, 0, 32'hBCBCBCBC, 4'hF);  lit("en0_bs", 32'hBCBCBCBC, 4'hF);
        drive(0, 0, 32'h12345678, 4'h2);  lit("en0_raw", 32'h12345678, 4'h2);
        drive(0, 1, 32'h0, 4'h0);         lit("en_rise", 32'h14C017FF, 4'h0);

        drive(0, 1, 32'hA5A5A5A5, 4'h0);
        drive(1, 1, 32'h000000BC, 4'h1);  lit("mid_reset", 32'h0, 4'h0);
        drive(0, 1, 32'h0, 4'h0);         lit("post_reset", 32'h14C017FF, 4'h0);
        drive(0, 1, 32'h000000BC, 4'h1);  lit("first_bs_sr", 32'hC017FF1C, 4'h1);

        // 513 BS words: SR on the first and the 513th
        drive(1, 1, 32'h0, 4'h0);
        for (int w = 1; w <= 513; w++) begin
            drive(0, 1, 32'h000000BC, 4'h1);
            if (w == 1 || w == 513) lit("bs_wrap_sr", 32'hC017FF1C, 4'h1);
            else if (w == 2) begin
                @(posedge clk); #1;
                check("bs_wrap_bs", {24'h0, outdata[7:0]}, 32'hBC);
            end
        end

        // bscnt at 511, then BS at byte1 and byte3 in one word
        drive(1, 1, 32'h0, 4'h0);
        for (int w = 0; w < 511; w++) drive(0, 1, 32'h000000BC, 4'h1);
        drive(0, 1, 32'hBC00BC00, 4'b1010);
        @(posedge clk); #1;
        check("multi_b1", {24'h0, outdata[15:8]}, 32'hBC);
        check("multi_b3", {24'h0, outdata[31:24]}, 32'h1C);

        for (int w = 0; w < 2000; w++) begin
            rd = $urandom;
            rk = '0;
            for (int b = 0; b < 4; b++) begin
                case ($urandom_range(0, 9))
                    0, 1: begin rd[8*b +: 8] = 8'hBC; rk[b] = 1'b1; end
                    2:    begin rd[8*b +: 8] = 8'h1C; rk[b] = 1'b1; end
                    3: begin
                        case ($urandom_range(0, 2))
                            0: by = 8'hFB;
                            1: by = 8'hFE;
                            default: by = 8'hF7;
                        endcase
                        rd[8*b +: 8] = by; rk[b] = 1'b1;
                    end
                    default: ;
                endcase
            end
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 29) != 0, rd, rk);
        end

        drive(0, 1, 32'h0, 4'h0);
        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
